// File: rtl/mult32_seq_if.sv
// Start/done handshake and operand/product bus between the ALU control
// and the sequential 32x32 multiplier.
interface mult32_seq_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  // ALU control side: issues requests and reads back the product
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/mult32_seq.sv
// Multi-cycle unsigned 32x32 shift-add multiplier. One 32-bit adder (add32)
// is reused once per iteration; the 64-bit product is {acc, q}.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; product of the last operation is held
// RUN   | one shift-add iteration per cycle, 32 cycles total
// DONE  | one-cycle done pulse, product valid from this cycle on

// 32-bit ripple-style adder with carry in/out; the only 32-bit adder in the
// multiplier datapath.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] r,
  output logic        c_out
);
  assign {c_out, r} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module mult32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         reset,
  mult32_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        mcand;
  logic [31:0]        acc;
  logic [31:0]        q;
  logic [CNT_W-1:0]   cnt;

  logic [31:0]        addend;
  logic [31:0]        sum;
  logic               carry;

  // The multiplicand is added only when the current multiplier bit is set.
  assign addend = q[0] ? mcand : 32'd0;

  add32 u_add32 (
    .a     (acc),
    .b     (addend),
    .c_in  (1'b0),
    .r     (sum),
    .c_out (carry)
  );

  // Sequencer and datapath registers; the carry-out lands in acc[31] on the
  // right shift, so no product bit is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.multiplicand;
            q     <= bus.multiplier;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          {acc, q} <= {carry, sum, q[31:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          // unused encoding recovers to IDLE
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = {acc, q};

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed corner cases plus random
// operands, compared against a plain 64-bit multiply.
module tb_mult32_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mult32_seq_if bus ();

  mult32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Issue one operation, wait for done. lat counts cycles from the accept
  // edge (cycle 1 follows it) to the cycle in which done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output logic [63:0] prod, output int lat, output bit ok);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    ok  = bus.done;
    while (!ok && lat < 100) begin
      if (scramble) begin
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      ok = bus.done;
    end
    prod = bus.product;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++;
    if (bus.product !== 64'd0) begin errors++; $display("FAIL reset_product got=%h exp=0", bus.product); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [63:0] p;
    int lat;
    bit ok;
    run_op(32'd3, 32'd5, 1'b0, p, lat, ok);
    checks++;
    if (!ok || lat != 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33 seen=%b", lat, ok); end
    checks++;
    if (p !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product got=%h exp=%h", p, 64'hF); end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got done=%b busy=%b exp 0/0", bus.done, bus.busy);
    end
    checks++;
    if (bus.product !== 64'hF) begin errors++; $display("FAIL basic_hold got=%h exp=%h", bus.product, 64'hF); end
  endtask

  task automatic test_max;
    logic [63:0] p;
    int lat;
    bit ok;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, ok);
    checks++;
    if (!ok || p !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL max_product got=%h exp=%h seen=%b", p, 64'hFFFF_FFFE_0000_0001, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edges;
    logic [63:0] p;
    int lat;
    bit ok;
    run_op(32'd0, 32'h1234_5678, 1'b0, p, lat, ok);
    checks++;
    if (!ok || p !== 64'd0) begin errors++; $display("FAIL zero_product got=%h exp=0 seen=%b", p, ok); end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'd2, 1'b0, p, lat, ok);
    checks++;
    if (!ok || p !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL msb_product got=%h exp=%h seen=%b", p, 64'h0000_0001_0000_0000, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [63:0] p;
    logic [31:0] a, b;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'd1;
      if (i == 1) b = 32'hFFFF_FFFF;
      run_op(a, b, 1'b1, p, lat, ok);
      checks++;
      if (!ok || lat != 33 || p !== ref_mul(a, b)) begin
        errors++;
        $display("FAIL random_%0d got=%h lat=%0d exp=%h lat=33 (a=%h b=%h)", i, p, lat, ref_mul(a, b), a, b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start;
    logic [63:0] p;
    int dones;
    int lat;
    int first_lat;
    p = '0;
    dones = 0;
    first_lat = 0;
    bus.start = 1'b1;
    bus.multiplicand = 32'hDEAD_BEEF;
    bus.multiplier   = 32'h0001_2345;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (lat = 1; lat < 60; lat++) begin
      if (lat == 10) begin
        bus.start = 1'b1;
        bus.multiplicand = 32'h0000_0007;
        bus.multiplier   = 32'h0000_0009;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (dones == 1) begin p = bus.product; first_lat = lat; end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++;
    if (first_lat != 33 || p !== ref_mul(32'hDEAD_BEEF, 32'h0001_2345)) begin
      errors++;
      $display("FAIL ignore_product got=%h lat=%0d exp=%h lat=33", p, first_lat, ref_mul(32'hDEAD_BEEF, 32'h0001_2345));
    end
  endtask

  task automatic test_abort;
    logic [63:0] p;
    int lat;
    int dones;
    bit ok;
    dones = 0;
    bus.start = 1'b1;
    bus.multiplicand = 32'hCAFE_F00D;
    bus.multiplier   = 32'hFFFF_0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b done=%b product=%h exp 0/0/0", bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d active cycles exp=0", dones); end
    run_op(32'd7, 32'd6, 1'b0, p, lat, ok);
    checks++;
    if (!ok || lat != 33 || p !== 64'd42) begin
      errors++; $display("FAIL abort_next got=%h lat=%0d exp=42 lat=33", p, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] prods [2];
    int edges [2];
    int dones;
    int n;
    prods[0] = '0; prods[1] = '0;
    edges[0] = 0;  edges[1] = 0;
    dones = 0;
    n = 0;
    bus.start = 1'b1;
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd3;
    @(posedge clk); #1;
    bus.multiplicand = 32'd4;
    bus.multiplier   = 32'd5;
    while (dones < 2 && n < 120) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        prods[dones] = bus.product;
        edges[dones] = n;
        dones++;
      end
      if (dones == 1 && bus.busy) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    checks++;
    if (prods[0] !== 64'd6 || prods[1] !== 64'd20) begin
      errors++; $display("FAIL b2b_products got=%0d,%0d exp=6,20", prods[0], prods[1]);
    end
    checks++;
    if (edges[1] - edges[0] != 34) begin
      errors++; $display("FAIL b2b_interval got=%0d exp=34", edges[1] - edges[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.product !== 64'd20) begin
      errors++; $display("FAIL b2b_settle got busy=%b product=%0d exp 0/20", bus.busy, bus.product);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    test_reset();
    test_basic();
    test_max();
    test_edges();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
